flush_ctrl: RTL

//  Sequences pipeline recovery after write-back commits an exception or ERTN.

---
 rtl/flush_ctrl_pkg.sv | 14 +
 rtl/flush_ctrl.sv | 80 ++++++++
 2 files changed

// File: rtl/flush_ctrl_pkg.sv
// Shared definitions for the pipeline-recovery flush controller.
package flush_ctrl_pkg;

    // Width of the flush-cycle down-counter (covers FLUSH_CYCLES up to 15).
    localparam int unsigned FC_CNT_WD = 4;

    // Encoding 2'd3 is never entered; if it is ever seen, the FSM returns to idle.
    typedef enum logic [1:0] {
        FC_IDLE     = 2'd0,
        FC_FLUSH    = 2'd1,
        FC_REDIRECT = 2'd2
    } fc_state_e;

endpackage

// File: rtl/flush_ctrl.sv
// Pipeline recovery sequencer: after WB commits an exception or ERTN it holds
// a global flush for FLUSH_CYCLES cycles, then hands the captured target to IF
// over a valid/ready redirect. Interrupt injection is blocked while busy.
module flush_ctrl
    import flush_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned INT_WIDTH    = 13
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 excp_req,
    input  logic                 ertn_req,
    input  logic [31:0]          eentry,
    input  logic [31:0]          era,
    input  logic                 crmd_ie,
    input  logic [INT_WIDTH-1:0] int_vec,
    output logic                 flush_all,
    output logic                 redirect_valid,
    output logic [31:0]          redirect_pc,
    input  logic                 redirect_ready,
    output logic                 int_req,
    output logic                 busy
);

    localparam logic [FC_CNT_WD-1:0] CntLoad = FC_CNT_WD'(FLUSH_CYCLES - 1);
    localparam logic [FC_CNT_WD-1:0] CntOne  = FC_CNT_WD'(1);

    fc_state_e            state_q;
    fc_state_e            state_d;
    logic [FC_CNT_WD-1:0] cnt_q;
    logic                 req;

    assign req = excp_req | ertn_req;

    // Next-state decode; requests outside idle are illegal and ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FC_IDLE:     if (req) state_d = FC_FLUSH;
            FC_FLUSH:    if (cnt_q == '0) state_d = FC_REDIRECT;
            FC_REDIRECT: if (redirect_ready) state_d = FC_IDLE;
            default:     state_d = FC_IDLE;
        endcase
    end

    // FSM state plus outputs registered from the next state, so they line up with it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= FC_IDLE;
            flush_all      <= 1'b0;
            redirect_valid <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state_q        <= state_d;
            flush_all      <= (state_d == FC_FLUSH);
            redirect_valid <= (state_d == FC_REDIRECT);
            busy           <= (state_d != FC_IDLE);
        end
    end

    // Target capture, flush counter and interrupt gating.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            redirect_pc <= '0;
            cnt_q       <= '0;
            int_req     <= 1'b0;
        end else begin
            if (state_q == FC_IDLE && req) begin
                // Exception takes priority over ERTN when both commit together.
                redirect_pc <= excp_req ? eentry : era;
                cnt_q       <= CntLoad;
            end else if (state_q == FC_FLUSH && cnt_q != '0) begin
                cnt_q <= cnt_q - CntOne;
            end
            int_req <= crmd_ie & (|int_vec) & (state_d == FC_IDLE);
        end
    end

endmodule
